// File: rtl/branch_pkg.sv
// ----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch resolution unit and its history table:
//   - opcode constants seen in the EX stage
//   - default datapath width
//   - sat_ctr_next(): next value of an up/down saturating counter
// ----------------------------------------------------------------------------
package branch_pkg;

    localparam logic [3:0] OP_BRANCH = 4'b0010;
    localparam logic [3:0] OP_ALU_R  = 4'b1100;
    localparam logic [3:0] OP_ALU_I  = 4'b0100;

    localparam int DBITS_DEFAULT = 32;

    // Counter value is passed zero-extended to 32 bits; 'bits' is the real
    // counter width. Taken moves up toward all-ones, not-taken down toward 0.
    function automatic logic [31:0] sat_ctr_next(input logic [31:0] ctr,
                                                 input logic        taken,
                                                 input int          bits);
        logic [31:0] max_val;
        max_val = (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        if (taken) begin
            return (ctr == max_val) ? ctr : ctr + 32'd1;
        end
        return (ctr == 32'd0) ? ctr : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/bht_table.sv
// ----------------------------------------------------------------------------
// bht_table
// Bimodal branch history table: ENTRIES saturating counters of CTR_BITS each.
// Ports:
//   clk, reset      clock, synchronous active-high reset (loads INIT_CTR)
//   i_rd_idx        combinational read index
//   o_rd_ctr        counter at i_rd_idx (pre-update value, no bypass)
//   i_wr_en         train the counter at i_wr_idx on this edge
//   i_wr_idx        training index
//   i_wr_taken      training direction (1 = increment, 0 = decrement)
// ----------------------------------------------------------------------------
module bht_table
    import branch_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2,
    parameter int INIT_CTR = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(ENTRIES)-1:0] i_rd_idx,
    output logic [CTR_BITS-1:0]        o_rd_ctr,
    input  logic                       i_wr_en,
    input  logic [$clog2(ENTRIES)-1:0] i_wr_idx,
    input  logic                       i_wr_taken
);

    logic [CTR_BITS-1:0] r_ctr [ENTRIES];
    logic [CTR_BITS-1:0] w_wr_next;

    assign o_rd_ctr  = r_ctr[i_rd_idx];
    assign w_wr_next = CTR_BITS'(sat_ctr_next(32'(r_ctr[i_wr_idx]), i_wr_taken, CTR_BITS));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= CTR_BITS'(INIT_CTR);
            end
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= w_wr_next;
        end
    end

endmodule

// File: rtl/branch_resolver_bht.sv
// ----------------------------------------------------------------------------
// branch_resolver_bht
// Resolves conditional branches in EX, trains a bimodal BHT and issues a
// registered flush/redirect. Provides a combinational direction prediction
// to fetch and keeps saturating branch / mispredict statistics.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   IF_PCNext         fetch PC+4, lookup address
//   IF_prediction     predicted direction (MSB of indexed counter)
//   EX_valid          EX holds a real instruction
//   EX_opcode         EX opcode; only OP_BRANCH is resolved
//   EX_PC             branch PC+4 (fall-through)
//   EX_PC_IMM         branch target
//   EX_condFlag       actual outcome (1 = taken)
//   EX_prediction     prediction carried from IF
//   correctOut        registered: prediction matched outcome
//   flush             registered: mispredict, squash and redirect
//   update            registered: a branch resolved last cycle
//   newPC             registered: redirect target, held when nothing resolves
//   stat_branches     saturating resolved-branch count
//   stat_mispredicts  saturating mispredict count
// ----------------------------------------------------------------------------
module branch_resolver_bht
    import branch_pkg::*;
#(
    parameter int DBITS    = DBITS_DEFAULT,
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2,
    parameter int INIT_CTR = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] IF_PCNext,
    output logic             IF_prediction,
    input  logic             EX_valid,
    input  logic [3:0]       EX_opcode,
    input  logic [DBITS-1:0] EX_PC,
    input  logic [DBITS-1:0] EX_PC_IMM,
    input  logic             EX_condFlag,
    input  logic             EX_prediction,
    output logic             correctOut,
    output logic             flush,
    output logic             update,
    output logic [DBITS-1:0] newPC,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispredicts
);

    localparam int IDX = $clog2(ENTRIES);

    logic             r_correct;
    logic             r_flush;
    logic             r_update;
    logic [DBITS-1:0] r_new_pc;
    logic [31:0]      r_stat_br;
    logic [31:0]      r_stat_mp;

    logic [IDX-1:0]      w_lookup_idx;
    logic [IDX-1:0]      w_ex_idx;
    logic [CTR_BITS-1:0] w_rd_ctr;
    logic                w_resolve;
    logic                w_correct;
    logic                w_unused;

    // Word-aligned index, no tag: aliasing between PCs is accepted.
    assign w_lookup_idx = IF_PCNext[IDX+1:2];
    assign w_ex_idx     = EX_PC[IDX+1:2];
    assign w_unused     = ^{IF_PCNext[DBITS-1:IDX+2], IF_PCNext[1:0]};

    // While flush is high the EX slot is wrong-path and must not train or count.
    assign w_resolve = EX_valid & (EX_opcode == OP_BRANCH) & ~r_flush;
    assign w_correct = (EX_prediction == EX_condFlag);

    bht_table #(
        .ENTRIES  (ENTRIES),
        .CTR_BITS (CTR_BITS),
        .INIT_CTR (INIT_CTR)
    ) u_bht (
        .clk        (clk),
        .reset      (reset),
        .i_rd_idx   (w_lookup_idx),
        .o_rd_ctr   (w_rd_ctr),
        .i_wr_en    (w_resolve),
        .i_wr_idx   (w_ex_idx),
        .i_wr_taken (EX_condFlag)
    );

    assign IF_prediction = w_rd_ctr[CTR_BITS-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_correct <= 1'b0;
            r_flush   <= 1'b0;
            r_update  <= 1'b0;
            r_new_pc  <= '0;
            r_stat_br <= '0;
            r_stat_mp <= '0;
        end else if (w_resolve) begin
            r_correct <= w_correct;
            r_flush   <= ~w_correct;
            r_update  <= 1'b1;
            r_new_pc  <= EX_condFlag ? EX_PC_IMM : EX_PC;
            if (r_stat_br != 32'hFFFF_FFFF) begin
                r_stat_br <= r_stat_br + 32'd1;
            end
            if (!w_correct && (r_stat_mp != 32'hFFFF_FFFF)) begin
                r_stat_mp <= r_stat_mp + 32'd1;
            end
        end else begin
            // newPC holds its last redirect target.
            r_correct <= 1'b0;
            r_flush   <= 1'b0;
            r_update  <= 1'b0;
        end
    end

    assign correctOut       = r_correct;
    assign flush            = r_flush;
    assign update           = r_update;
    assign newPC            = r_new_pc;
    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mp;

endmodule

// File: tb/tb_branch_resolver_bht.sv
module tb_branch_resolver_bht;

  localparam logic [3:0] OP_BR  = 4'b0010;
  localparam logic [3:0] OP_ALR = 4'b1100;
  localparam logic [3:0] OP_ALI = 4'b0100;
  localparam int EW = 99;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] IF_PCNext;
  logic        IF_prediction;
  logic        EX_valid;
  logic [3:0]  EX_opcode;
  logic [31:0] EX_PC;
  logic [31:0] EX_PC_IMM;
  logic        EX_condFlag;
  logic        EX_prediction;
  logic        correctOut;
  logic        flush;
  logic        update;
  logic [31:0] newPC;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  branch_resolver_bht dut (
    .clk              (clk),
    .reset            (reset),
    .IF_PCNext        (IF_PCNext),
    .IF_prediction    (IF_prediction),
    .EX_valid         (EX_valid),
    .EX_opcode        (EX_opcode),
    .EX_PC            (EX_PC),
    .EX_PC_IMM        (EX_PC_IMM),
    .EX_condFlag      (EX_condFlag),
    .EX_prediction    (EX_prediction),
    .correctOut       (correctOut),
    .flush            (flush),
    .update           (update),
    .newPC            (newPC),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  // ---------------- reference model ----------------
  int          m_ctr [64];
  logic        m_correct, m_flush, m_update;
  logic [31:0] m_newpc, m_br, m_mp;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_pred(input logic [31:0] pc);
    return (m_ctr[pc[7:2]] >= 2) ? 1'b1 : 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    m_correct = 1'b0; m_flush = 1'b0; m_update = 1'b0;
    m_newpc = '0; m_br = '0; m_mp = '0;
  endtask

  // ---------------- driver: one clock of stimulus ----------------
  // Drives inputs, checks the pre-edge lookup, advances the model, pushes the
  // expected registered outputs, then pops and compares after the edge.
  task automatic cycle(input logic rst, input logic v, input logic [3:0] op,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic cond, input logic pred, input logic [31:0] lk);
    logic          res;
    logic [EW-1:0] e;
    reset = rst; EX_valid = v; EX_opcode = op; EX_PC = pc; EX_PC_IMM = imm;
    EX_condFlag = cond; EX_prediction = pred; IF_PCNext = lk;
    #1;
    check("pred_pre_edge", {31'b0, IF_prediction}, {31'b0, model_pred(lk)});
    if (rst) begin
      model_reset();
    end else begin
      res = v && (op == OP_BR) && !m_flush;
      if (res) begin
        m_correct = (pred == cond);
        m_flush   = (pred != cond);
        m_update  = 1'b1;
        m_newpc   = cond ? imm : pc;
        if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
        if (pred != cond && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
        if (cond && m_ctr[pc[7:2]] < 3) m_ctr[pc[7:2]]++;
        else if (!cond && m_ctr[pc[7:2]] > 0) m_ctr[pc[7:2]]--;
      end else begin
        m_correct = 1'b0; m_flush = 1'b0; m_update = 1'b0;
      end
    end
    exp_q.push_back({m_correct, m_flush, m_update, m_newpc, m_br, m_mp});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: queue empty, expected 1 entry");
    end else begin
      e = exp_q.pop_front();
      check("correctOut", {31'b0, correctOut}, {31'b0, e[98]});
      check("flush", {31'b0, flush}, {31'b0, e[97]});
      check("update", {31'b0, update}, {31'b0, e[96]});
      check("newPC", newPC, e[95:64]);
      check("stat_branches", stat_branches, e[63:32]);
      check("stat_mispredicts", stat_mispredicts, e[31:0]);
    end
    check("pred_post_edge", {31'b0, IF_prediction}, {31'b0, model_pred(lk)});
  endtask

  task automatic idle(input logic [31:0] lk);
    cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, lk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  op;
    logic [31:0] pc;
    reset = 1'b1; EX_valid = 1'b0; EX_opcode = 4'h0; EX_PC = '0; EX_PC_IMM = '0;
    EX_condFlag = 1'b0; EX_prediction = 1'b0; IF_PCNext = 32'h4;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    // Reset state
    check("rst_pred", {31'b0, IF_prediction}, 32'd0);
    check("rst_correctOut", {31'b0, correctOut}, 32'd0);
    check("rst_flush", {31'b0, flush}, 32'd0);
    check("rst_update", {31'b0, update}, 32'd0);
    check("rst_newPC", newPC, 32'd0);
    check("rst_stat_br", stat_branches, 32'd0);
    check("rst_stat_mp", stat_mispredicts, 32'd0);

    // Correct taken prediction, first resolve right after reset; same-index
    // lookup shows old counter (1 -> predicts 0) then 2 (predicts 1).
    cycle(1'b0, 1'b1, OP_BR, 32'h4, 32'h8, 1'b1, 1'b1, 32'h4);
    // Mispredict: predicted taken, not taken -> redirect to fall-through.
    cycle(1'b0, 1'b1, OP_BR, 32'h4, 32'h8, 1'b0, 1'b1, 32'h4);
    idle(32'h4);
    // Mispredict the other way, then a branch in the shadow is ignored.
    cycle(1'b0, 1'b1, OP_BR, 32'h4, 32'h8, 1'b1, 1'b0, 32'h4);
    cycle(1'b0, 1'b1, OP_BR, 32'h4, 32'h8, 1'b1, 1'b1, 32'h4);
    idle(32'h4);
    // Saturate counter[1] at 3 with back-to-back correct branches.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, OP_BR, 32'h4, 32'h10, 1'b1, 1'b1, 32'h4);
    // Aliasing PC 0x104 trains index 1 down to 2; lookup at 0x4 still 1.
    cycle(1'b0, 1'b1, OP_BR, 32'h104, 32'h200, 1'b0, 1'b1, 32'h4);
    idle(32'h4);
    // Same-index lookup while counter goes 2 -> 1: old value predicts 1.
    cycle(1'b0, 1'b1, OP_BR, 32'h4, 32'h8, 1'b0, 1'b1, 32'h4);
    idle(32'h4);
    // Non-branch opcodes and an invalid branch have no effect.
    cycle(1'b0, 1'b1, OP_ALR, 32'h4, 32'h8, 1'b1, 1'b0, 32'h4);
    cycle(1'b0, 1'b1, OP_ALI, 32'h4, 32'h8, 1'b1, 1'b0, 32'h4);
    cycle(1'b0, 1'b0, OP_BR, 32'h4, 32'h8, 1'b1, 1'b0, 32'h4);

    // Random traffic over a few aliasing PCs.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: op = OP_ALR;
        1: op = OP_ALI;
        default: op = OP_BR;
      endcase
      pc = {22'b0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'b00};
      cycle(1'b0, 1'($urandom_range(0, 1) | $urandom_range(0, 1)), op, pc,
            $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            {22'b0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'b00});
    end

    // Reset asserted during a flush cycle, with a branch still presented.
    idle(32'h4);
    cycle(1'b0, 1'b1, OP_BR, 32'h4, 32'h8, 1'b1, 1'b0, 32'h4);
    check("flush_before_reset", {31'b0, flush}, 32'd1);
    cycle(1'b1, 1'b1, OP_BR, 32'h4, 32'h8, 1'b1, 1'b0, 32'h4);
    check("ctr1_after_reset_pred", {31'b0, IF_prediction}, 32'd0);
    check("stats_after_reset", stat_branches | stat_mispredicts, 32'd0);
    cycle(1'b0, 1'b1, OP_ALR, 32'h4, 32'h8, 1'b1, 1'b0, 32'h4);
    cycle(1'b0, 1'b1, OP_BR, 32'h4, 32'h8, 1'b1, 1'b1, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolver_bht.md
# branch_resolver_bht

Parametrised branch resolution unit with a built-in bimodal branch history table (BHT) of saturating counters. It sits at the EX/MEM boundary and provides the fetch stage with a direction prediction. It resolves conditional branches in EX, trains the table, and issues a registered flush/redirect to the pipeline. Saturating branch and mispredict statistics counters are included.

## Interface
Parameters:
- DBITS, 32, datapath/PC width
- ENTRIES, 64, number of BHT entries; power of two, at least 2
- CTR_BITS, 2, width of each saturating counter; at least 1
- INIT_CTR, 1, counter value after reset (weakly not-taken for 2 bits)

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- IF_PCNext  in  DBITS  fetch stage's PC+4, used for the lookup
- IF_prediction  out  1  combinational; MSB of counter[IF_PCNext[IDX+1:2]]
- EX_valid  in  1  EX holds a real instruction
- EX_opcode  in  4  EX opcode; only OP_BRANCH (4'b0010) is resolved
- EX_PC  in  DBITS  branch PC+4, which is the fall-through address
- EX_PC_IMM  in  DBITS  branch target
- EX_condFlag  in  1  actual outcome (1 = taken)
- EX_prediction  in  1  prediction carried with the branch from IF
- correctOut  out  1  registered; prediction matched outcome
- flush  out  1  registered; mispredict, pipeline must squash and redirect
- update  out  1  registered; a branch was resolved last cycle
- newPC  out  DBITS  registered; redirect target, valid when update=1
- stat_branches  out  32  resolved-branch count, saturates at 32'hFFFFFFFF
- stat_mispredicts  out  32  mispredict count, saturates at 32'hFFFFFFFF

## Operation
- IDX = log2(ENTRIES). Index = PC[IDX+1:2] on both the lookup and update sides. There is no tag, so aliasing is accepted.
- Resolve condition: `resolve = EX_valid & (EX_opcode == OP_BRANCH) & ~flush`.
  - While flush=1, the EX instruction is wrong-path and is ignored. No table write, no statistics change.
- On resolve, the following take effect at the next edge:
  - `correctOut = (EX_prediction == EX_condFlag)`
  - `flush = ~correctOut`
  - `update = 1`
  - `newPC = EX_condFlag ? EX_PC_IMM : EX_PC`
  - counter[idx]: +1 if taken, saturating at 2^CTR_BITS-1; -1 if not taken, saturating at 0.
  - stat_branches +1; stat_mispredicts +1 on a mispredict. Both saturate.
- When resolve=0, the next edge sets correctOut=0, flush=0, update=0 and holds newPC.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update value. There is no bypass.
- Non-branch opcodes (ALU_R 4'b1100, ALU_I 4'b0100, and all others) have no effect.

## Timing
- Prediction is combinational, with zero latency from IF_PCNext.
- Resolution latency is 1 cycle: EX inputs sampled at edge N produce outputs valid after edge N. flush is high for exactly one cycle per mispredict.
- Back-to-back correctly-predicted branches resolve every cycle.
- Reset (synchronous, highest priority, including mid-flush) does the following at that edge:
  - correctOut=0, flush=0, update=0, newPC=0
  - all counters set to INIT_CTR
  - both statistics counters set to 0
  - The first resolve can occur in the cycle after reset deasserts.

## Structure
- Package branch_pkg holds:
  - opcode constants OP_BRANCH=4'b0010, OP_ALU_R=4'b1100, OP_ALU_I=4'b0100
  - the DBITS default
  - a function computing the saturating counter next value
- Sub-module bht_table (ENTRIES, CTR_BITS, INIT_CTR) provides:
  - a flop array with one combinational read port and one synchronous write port (write enable, index, taken)
  - synchronous reset initialisation
- The resolution, flush shadow, output registers and statistics counters live in the top level.

## Test plan
Defaults are used throughout (ENTRIES=64, index = PC[7:2]).
- Reset, then IF_PCNext=0x4 -> IF_prediction=0; all outputs 0; stats 0.
- EX_PC=0x4, EX_PC_IMM=0x8, cond=1, pred=1, branch -> next cycle correctOut=1, flush=0, update=1, newPC=0x8; counter[1] 1→2; lookup at 0x4 now predicts 1; stat_branches=1.
- Same branch with cond=0, pred=1 -> flush=1, correctOut=0, newPC=0x4, stat_mispredicts=1.
- pred=0, cond=1 -> flush=1, newPC=0x8. Present a valid branch on the following cycle -> update=0, no counter change, stats unchanged.
- Saturation and aliasing:
  - Four taken updates at EX_PC=0x4 -> counter[1]=3.
  - One not-taken update at EX_PC=0x104 (aliases to index 1) -> counter=2, lookup at 0x4 still predicts 1.
  - Lookup and update at the same index in the same cycle -> the lookup shows the old value.
- Assert reset during a flush cycle -> next edge gives all outputs 0, counter[1]=1, stats 0. ALU_R/ALU_I opcodes with EX_valid=1 -> update stays 0.
